// File: rtl/sync_debounce_multi.sv
// Multi-channel level synchronizer with per-channel debounce filter.
// Each channel runs an in->sync_raw flop chain, a stability counter and registered rise/fall pulses.
module sync_debounce_multi #(
  parameter int               WIDTH     = 4,
  parameter int               STAGES    = 3,
  parameter int               DEBOUNCE  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] sync_raw,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int             CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [CW-1:0]    cnt_q   [WIDTH];

  // Synchronizer chain: only stage_q[1] ever observes the possibly metastable stage_q[0].
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= RESET_VAL;
    end else begin
      stage_q[0] <= in;
      for (int k = 1; k < STAGES; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign sync_raw = stage_q[STAGES-1];

  // A new level is accepted on the DEBOUNCE-th consecutive cycle it differs from out;
  // any return to out restarts the count, so the counter never passes DEBOUNCE-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      out  <= RESET_VAL;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_raw[i] == out[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] != CNT_LAST) begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end else begin
          out[i]   <= sync_raw[i];
          cnt_q[i] <= '0;
          rise[i]  <= sync_raw[i];
          fall[i]  <= ~sync_raw[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_debounce_multi.sv
// Directed bench for sync_debounce_multi: expected pulse events are queued by the stimulus
// and consumed by per-DUT monitors whenever rise or fall is nonzero.
module tb_sync_debounce_multi;

  localparam int W = 44; // {cycle[31:0], out[3:0], rise[3:0], fall[3:0]}

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in;
  logic [3:0] sync_raw, out, rise, fall;

  logic       rst_m;
  logic [3:0] in_m;
  logic [3:0] sync_raw_m, out_m, rise_m, fall_m;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_m_q[$];

  sync_debounce_multi #(.WIDTH(4), .STAGES(3), .DEBOUNCE(4), .RESET_VAL(4'h0)) dut (
    .clk(clk), .rst(rst), .in(in),
    .sync_raw(sync_raw), .out(out), .rise(rise), .fall(fall)
  );

  sync_debounce_multi #(.WIDTH(4), .STAGES(2), .DEBOUNCE(1), .RESET_VAL(4'hF)) dut_min (
    .clk(clk), .rst(rst_m), .in(in_m),
    .sync_raw(sync_raw_m), .out(out_m), .rise(rise_m), .fall(fall_m)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int c, input logic [3:0] o, input logic [3:0] r, input logic [3:0] f);
    exp_q.push_back({c[31:0], o, r, f});
  endtask

  task automatic push_exp_m(input int c, input logic [3:0] o, input logic [3:0] r, input logic [3:0] f);
    exp_m_q.push_back({c[31:0], o, r, f});
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (|(rise | fall)) begin
      if (exp_q.size() == 0) begin
        check("main_unexpected_pulse", {24'h0, rise, fall}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("main_pulse_cycle", cyc, e[43:12]);
        check("main_out", {28'h0, out}, {28'h0, e[11:8]});
        check("main_rise", {28'h0, rise}, {28'h0, e[7:4]});
        check("main_fall", {28'h0, fall}, {28'h0, e[3:0]});
      end
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (|(rise_m | fall_m)) begin
      if (exp_m_q.size() == 0) begin
        check("min_unexpected_pulse", {24'h0, rise_m, fall_m}, 32'h0);
      end else begin
        e = exp_m_q.pop_front();
        check("min_pulse_cycle", cyc, e[43:12]);
        check("min_out", {28'h0, out_m}, {28'h0, e[11:8]});
        check("min_rise", {28'h0, rise_m}, {28'h0, e[7:4]});
        check("min_fall", {28'h0, fall_m}, {28'h0, e[3:0]});
      end
    end
  end

  // Driver
  initial begin
    int t;
    rst   = 1'b1;
    in    = 4'hF;
    rst_m = 1'b1;
    in_m  = 4'hF;
    wait_cycles(2);
    check("reset_out", {28'h0, out}, 32'h0);
    check("reset_sync_raw", {28'h0, sync_raw}, 32'h0);
    check("reset_rise_fall", {24'h0, rise, fall}, 32'h0);
    check("min_reset_out", {28'h0, out_m}, 32'hF);
    check("min_reset_sync_raw", {28'h0, sync_raw_m}, 32'hF);

    // Release reset with in=F: all channels rise after STAGES+DEBOUNCE edges
    rst   = 1'b0;
    rst_m = 1'b0;
    t = cyc;
    push_exp(t + 7, 4'hF, 4'hF, 4'h0);
    wait_cycles(3);
    check("post_reset_sync_raw", {28'h0, sync_raw}, 32'hF);
    check("post_reset_out_before", {28'h0, out}, 32'h0);
    wait_cycles(5);
    check("post_reset_out", {28'h0, out}, 32'hF);
    check("post_reset_rise_width", {28'h0, rise}, 32'h0);

    // Drop all to zero
    in = 4'h0;
    t = cyc;
    push_exp(t + 7, 4'h0, 4'h0, 4'hF);
    wait_cycles(10);

    // Clean edge on bit 0
    in = 4'h1;
    t = cyc;
    push_exp(t + 7, 4'h1, 4'h1, 4'h0);
    wait_cycles(3);
    check("clean_sync_raw", {28'h0, sync_raw}, 32'h1);
    wait_cycles(3);
    check("clean_out_before", {28'h0, out}, 32'h0);
    wait_cycles(2);
    check("clean_rise_width", {28'h0, rise}, 32'h0);
    check("clean_out_after", {28'h0, out}, 32'h1);
    wait_cycles(2);

    // 2-cycle glitch on bit 1: rejected
    in = 4'h3;
    wait_cycles(2);
    in = 4'h1;
    wait_cycles(1);
    check("glitch_sync_raw_high", {28'h0, sync_raw}, 32'h3);
    wait_cycles(2);
    check("glitch_sync_raw_low", {28'h0, sync_raw}, 32'h1);
    wait_cycles(7);
    check("glitch_out", {28'h0, out}, 32'h1);

    // 4-cycle pulse on bit 1: accepted, rise then fall 4 cycles apart
    in = 4'h3;
    t = cyc;
    push_exp(t + 7, 4'h3, 4'h2, 4'h0);
    push_exp(t + 11, 4'h1, 4'h0, 4'h2);
    wait_cycles(4);
    in = 4'h1;
    wait_cycles(10);

    // Bring bit 3 high, then bit 2 up and bit 3 down together
    in = 4'h9;
    t = cyc;
    push_exp(t + 7, 4'h9, 4'h8, 4'h0);
    wait_cycles(10);
    in = 4'h5;
    t = cyc;
    push_exp(t + 7, 4'h5, 4'h4, 4'h8);
    wait_cycles(10);

    // Reset mid-count: drop bit 0, reset 5 cycles later
    in = 4'h4;
    t = cyc;
    wait_cycles(5);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    check("midreset_out", {28'h0, out}, 32'h0);
    check("midreset_rise_fall", {24'h0, rise, fall}, 32'h0);
    t = cyc;
    push_exp(t + 7, 4'h4, 4'h4, 4'h0); // bit 2 is still high at the input
    wait_cycles(10);
    check("midreset_out_final", {28'h0, out}, 32'h4);

    // Minimal config: drop bit 0, then a 1-cycle-wide pulse passes
    in_m = 4'hE;
    t = cyc;
    push_exp_m(t + 3, 4'hE, 4'h0, 4'h1);
    wait_cycles(2);
    check("min_sync_raw", {28'h0, sync_raw_m}, 32'hE);
    wait_cycles(4);
    in_m = 4'hF;
    t = cyc;
    push_exp_m(t + 3, 4'hF, 4'h1, 4'h0);
    push_exp_m(t + 4, 4'hE, 4'h0, 4'h1);
    wait_cycles(1);
    in_m = 4'hE;
    wait_cycles(8);

    check("main_queue_drained", exp_q.size(), 32'h0);
    check("min_queue_drained", exp_m_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_debounce_multi.md
# sync_debounce_multi

Multi-channel successor to the single-bit flop-chain synchronizer. It brings WIDTH asynchronous level inputs (buttons, straps, status lines from foreign domains) into the clk domain through a parametrised STAGES-deep flop chain. Each synchronized channel is then debounced by a per-channel stability counter. The block emits a filtered level plus single-cycle rise/fall pulses, so downstream logic needs no separate edge detector or glitch filter.

## Interface
- WIDTH, 4: number of independent channels (≥1).
- STAGES, 3: synchronizer flops per channel (≥2).
- DEBOUNCE, 4: consecutive stable cycles required before the filtered level changes (≥1; 1 = no filtering beyond one register).
- RESET_VAL, {WIDTH{1'b0}}: per-channel reset level of the chain, filtered output and internal state.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  WIDTH  asynchronous level inputs; no timing relationship to clk.
- sync_raw  output  WIDTH  last chain stage per channel (synchronized, unfiltered).
- out  output  WIDTH  debounced level per channel.
- rise  output  WIDTH  1-cycle pulse in the cycle out[i] goes 0→1.
- fall  output  WIDTH  1-cycle pulse in the cycle out[i] goes 1→0.

## Operation
- Channels are fully independent; no shared state except clk and rst.
- Chain: stage[0] <= in[i], stage[k] <= stage[k-1]. sync_raw[i] = stage[STAGES-1]. Nothing reads stage[0] except stage[1].
- Debounce counter cnt[i], width $clog2(DEBOUNCE+1), saturates at no value; it is always cleared before overflow.
  - sync_raw[i] == out[i]: cnt <= 0.
  - sync_raw[i] != out[i] and cnt != DEBOUNCE-1: cnt <= cnt+1.
  - sync_raw[i] != out[i] and cnt == DEBOUNCE-1: out[i] <= sync_raw[i], cnt <= 0, and rise[i] or fall[i] is asserted for that one cycle per the new value.
- rise/fall are registered and coincide with the cycle in which out shows the new value. They are never both high on one channel.
- Glitch rejection: any sync_raw deviation lasting fewer than DEBOUNCE cycles leaves out unchanged and produces no pulse. A deviation of exactly DEBOUNCE cycles is accepted.
- Bounce: each return of sync_raw to out restarts the count from 0.
- Reset (rst=1 at an edge): every stage, out[i] <= RESET_VAL[i], cnt <= 0, rise = fall = 0. This holds mid-count or mid-pulse; an in-flight change is discarded. Inputs are ignored while rst is high.
- After reset release, an input differing from RESET_VAL is treated as a normal change and produces a pulse after full latency.

## Timing
- Reset values: sync_raw = out = RESET_VAL, rise = fall = 0, from the first edge with rst=1.
- Edge 1 is the first clk edge sampling a new stable level on in[i].
- sync_raw[i] updates after edge STAGES.
- out[i] and the rise/fall pulse update after edge STAGES+DEBOUNCE. Total latency is STAGES+DEBOUNCE cycles, ±1 cycle for metastability resolution of an input changing at the sampling edge.
- Pulse width is exactly 1 cycle.
- Minimum spacing between two accepted transitions on one channel is DEBOUNCE cycles.
- No combinational path from in to any output.

## Test plan
All scenarios use a 10 ns clk and WIDTH=4, STAGES=3, DEBOUNCE=4, RESET_VAL=0 unless stated.
- Reset: rst=1 for 2 edges with in=4'hF -> out=0, sync_raw=0, rise=fall=0 throughout reset. After release, rise=4'hF pulses 1 cycle at edge 7 and out=4'hF.
- Clean edge: in[0] 0→1 held -> sync_raw[0]=1 after edge 3, out[0]=1 and rise[0]=1 after edge 7, rise[0]=0 after edge 8.
- Glitch: in[1] high for 2 cycles, then low -> sync_raw[1] pulses 2 cycles. out[1], rise[1] and fall[1] stay 0. A 4-cycle pulse is accepted with rise then fall, 4 cycles apart.
- Simultaneous/independent: with out[3]=1, drive in[2] 0→1 and in[3] 1→0 on the same edge -> rise[2] and fall[3] are high on the same cycle, and other bits are unaffected.
- Reset mid-count: with out[0]=1, drop in[0] and assert rst 5 cycles later for 1 edge -> out[0]=0 (RESET_VAL) with no fall pulse. After release, with in[0] held 0, no pulse occurs.
- Minimal config: STAGES=2, DEBOUNCE=1, RESET_VAL=4'hF. Drop in[0] -> fall[0] pulses and out[0]=0 after edge 3. A 1-cycle-wide sync_raw pulse passes through.
